// File: rtl/dual_edge_encoder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dual_edge_encoder_if : event/level-line bundle for the dual-edge encoder
// Revision: 1.0
// ---------------------------------------------------------------------------
interface dual_edge_encoder_if #(
  parameter int PEND_W = 4
);
  logic              event_in;
  logic              clear_ovf;
  logic              line_out;
  logic [PEND_W-1:0] pending;
  logic              busy;
  logic              overflow;

  modport master (
    output event_in,
    output clear_ovf,
    input  line_out,
    input  pending,
    input  busy,
    input  overflow
  );

  modport slave (
    input  event_in,
    input  clear_ovf,
    output line_out,
    output pending,
    output busy,
    output overflow
  );
endinterface
`default_nettype wire

// File: rtl/dual_edge_encoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dual_edge_encoder : turns event strobes into spaced transitions on a level line
// Revision: 1.0
// ---------------------------------------------------------------------------
module dual_edge_encoder #(
  parameter int HOLD_CYCLES = 2,
  parameter int PEND_W      = 4
) (
  input  wire logic           clk,
  input  wire logic           reset_n,
  dual_edge_encoder_if.slave  bus
);

  localparam logic [7:0]        c_HOLD_RELOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [PEND_W-1:0] c_PEND_MAX    = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] c_PEND_ONE    = {{(PEND_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_hold_cnt;
  logic [7:0]        w_hold_cnt_nxt;
  logic              r_line;
  logic [PEND_W-1:0] r_pending;
  logic [PEND_W-1:0] w_pending_nxt;
  logic              r_overflow;
  logic              w_overflow_nxt;
  logic              w_work;
  logic              w_toggle;
  logic              w_drop;

  always_comb begin
    w_work         = bus.event_in | (r_pending != '0);
    w_toggle       = 1'b0;
    w_state_nxt    = r_state;
    w_hold_cnt_nxt = r_hold_cnt;
    case (r_state)
      ST_IDLE: begin
        if (bus.event_in) begin
          w_toggle    = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (r_hold_cnt != 8'd0) begin
          w_hold_cnt_nxt = r_hold_cnt - 8'd1;
        end else if (w_work) begin
          w_toggle = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (w_toggle) begin
      w_hold_cnt_nxt = c_HOLD_RELOAD;
    end
  end

  // An event that coincides with a toggle reuses the emitted slot, so the count holds.
  always_comb begin
    w_pending_nxt = r_pending;
    w_drop        = 1'b0;
    case ({bus.event_in, w_toggle})
      2'b10: begin
        if (r_pending != c_PEND_MAX) begin
          w_pending_nxt = r_pending + c_PEND_ONE;
        end else begin
          w_drop = 1'b1;
        end
      end
      2'b01: begin
        if (r_pending != '0) begin
          w_pending_nxt = r_pending - c_PEND_ONE;
        end
      end
      default: begin
        w_pending_nxt = r_pending;
      end
    endcase
    if (w_drop) begin
      w_overflow_nxt = 1'b1;
    end else if (bus.clear_ovf) begin
      w_overflow_nxt = 1'b0;
    end else begin
      w_overflow_nxt = r_overflow;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_hold_cnt <= 8'd0;
      r_line     <= 1'b0;
      r_pending  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_line     <= r_line ^ w_toggle;
      r_pending  <= w_pending_nxt;
      r_overflow <= w_overflow_nxt;
    end
  end

  assign bus.line_out = r_line;
  assign bus.pending  = r_pending;
  assign bus.overflow = r_overflow;
  assign bus.busy     = (r_state == ST_HOLD) | (r_pending != '0);

endmodule
`default_nettype wire

// File: tb/tb_dual_edge_encoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dual_edge_encoder : four encoder configurations against a timing-based model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_dual_edge_encoder;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic ev;
  logic clr;

  always #5 clk = ~clk;

  dual_edge_encoder_if #(.PEND_W(4)) if_a ();
  dual_edge_encoder_if #(.PEND_W(2)) if_b ();
  dual_edge_encoder_if #(.PEND_W(8)) if_c ();
  dual_edge_encoder_if #(.PEND_W(3)) if_d ();

  assign if_a.event_in = ev;  assign if_a.clear_ovf = clr;
  assign if_b.event_in = ev;  assign if_b.clear_ovf = clr;
  assign if_c.event_in = ev;  assign if_c.clear_ovf = clr;
  assign if_d.event_in = ev;  assign if_d.clear_ovf = clr;

  dual_edge_encoder #(.HOLD_CYCLES(2), .PEND_W(4)) u_a (.clk(clk), .reset_n(reset_n), .bus(if_a));
  dual_edge_encoder #(.HOLD_CYCLES(4), .PEND_W(2)) u_b (.clk(clk), .reset_n(reset_n), .bus(if_b));
  dual_edge_encoder #(.HOLD_CYCLES(2), .PEND_W(8)) u_c (.clk(clk), .reset_n(reset_n), .bus(if_c));
  dual_edge_encoder #(.HOLD_CYCLES(1), .PEND_W(3)) u_d (.clk(clk), .reset_n(reset_n), .bus(if_d));

  logic       line_o [N];
  logic [7:0] pend_o [N];
  logic       busy_o [N];
  logic       ovf_o  [N];

  assign line_o[0] = if_a.line_out; assign pend_o[0] = 8'(if_a.pending);
  assign busy_o[0] = if_a.busy;     assign ovf_o[0]  = if_a.overflow;
  assign line_o[1] = if_b.line_out; assign pend_o[1] = 8'(if_b.pending);
  assign busy_o[1] = if_b.busy;     assign ovf_o[1]  = if_b.overflow;
  assign line_o[2] = if_c.line_out; assign pend_o[2] = 8'(if_c.pending);
  assign busy_o[2] = if_c.busy;     assign ovf_o[2]  = if_c.overflow;
  assign line_o[3] = if_d.line_out; assign pend_o[3] = 8'(if_d.pending);
  assign busy_o[3] = if_d.busy;     assign ovf_o[3]  = if_d.overflow;

  // Reference model: an edge may be emitted once HOLD cycles have passed since the last one.
  int hold_cfg [N] = '{2, 4, 2, 1};
  int pmax_cfg [N] = '{15, 3, 255, 7};
  int pend_m   [N];
  int next_ok  [N];
  bit line_m   [N];
  bit ovf_m    [N];
  bit active_m [N];
  int k = 0;

  int total = 0;
  int bad   = 0;

  function automatic void model_init();
    for (int d = 0; d < N; d++) begin
      pend_m[d]   = 0;
      next_ok[d]  = 0;
      line_m[d]   = 1'b0;
      ovf_m[d]    = 1'b0;
      active_m[d] = 1'b0;
    end
  endfunction

  function automatic void model_step(bit e, bit c);
    for (int d = 0; d < N; d++) begin
      bit can;
      bit t;
      bit drop;
      can  = (k >= next_ok[d]);
      t    = can && (e || pend_m[d] > 0);
      drop = 1'b0;
      if (t) begin
        line_m[d]   = ~line_m[d];
        next_ok[d]  = k + hold_cfg[d];
        active_m[d] = 1'b1;
      end else if (can) begin
        active_m[d] = 1'b0;
      end
      if (e && !t) begin
        if (pend_m[d] < pmax_cfg[d]) pend_m[d]++;
        else drop = 1'b1;
      end else if (t && !e) begin
        pend_m[d]--;
      end
      if (drop) ovf_m[d] = 1'b1;
      else if (c) ovf_m[d] = 1'b0;
    end
    k++;
  endfunction

  function automatic bit busy_m(int d);
    return active_m[d] || (pend_m[d] > 0);
  endfunction

  task automatic tick(input bit e, input bit c);
    ev  = e;
    clr = c;
    model_step(e, c);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
    model_init();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    ev      = 1'b0;
    clr     = 1'b0;
    @(posedge clk);
    #1;
    for (int d = 0; d < N; d++) begin
      total++; if (line_o[d] !== 1'b0) begin bad++; $display("FAIL reset_line[%0d]: got %0d expected 0", d, line_o[d]); end
      total++; if (pend_o[d] !== 8'd0) begin bad++; $display("FAIL reset_pend[%0d]: got %0d expected 0", d, pend_o[d]); end
      total++; if (busy_o[d] !== 1'b0) begin bad++; $display("FAIL reset_busy[%0d]: got %0d expected 0", d, busy_o[d]); end
      total++; if (ovf_o[d]  !== 1'b0) begin bad++; $display("FAIL reset_ovf[%0d]: got %0d expected 0", d, ovf_o[d]); end
    end
    #3;
    reset_n = 1'b1;
    model_init();
  endtask

  task automatic test_single();
    do_reset();
    repeat (4) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    total++; if (line_o[0] !== 1'b1) begin bad++; $display("FAIL single_line: got %0d expected 1", line_o[0]); end
    total++; if (busy_o[0] !== 1'b1) begin bad++; $display("FAIL single_busy0: got %0d expected 1", busy_o[0]); end
    total++; if (pend_o[0] !== 8'd0) begin bad++; $display("FAIL single_pend: got %0d expected 0", pend_o[0]); end
    tick(1'b0, 1'b0);
    total++; if (busy_o[0] !== 1'b1) begin bad++; $display("FAIL single_busy1: got %0d expected 1", busy_o[0]); end
    tick(1'b0, 1'b0);
    total++; if (busy_o[0] !== 1'b0) begin bad++; $display("FAIL single_idle: got %0d expected 0", busy_o[0]); end
    total++; if (line_o[0] !== 1'b1) begin bad++; $display("FAIL single_hold_line: got %0d expected 1", line_o[0]); end
  endtask

  task automatic test_burst();
    int pexp [5] = '{0, 1, 1, 1, 0};
    bit lexp [5] = '{1, 1, 0, 0, 1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(i < 3, 1'b0);
      total++; if (pend_o[0] !== 8'(pexp[i])) begin bad++; $display("FAIL burst_pend[%0d]: got %0d expected %0d", i, pend_o[0], pexp[i]); end
      total++; if (line_o[0] !== lexp[i]) begin bad++; $display("FAIL burst_line[%0d]: got %0d expected %0d", i, line_o[0], lexp[i]); end
    end
    tick(1'b0, 1'b0);
    total++; if (busy_o[0] !== 1'b1) begin bad++; $display("FAIL burst_busy_tail: got %0d expected 1", busy_o[0]); end
    tick(1'b0, 1'b0);
    total++; if (busy_o[0] !== 1'b0) begin bad++; $display("FAIL burst_busy_end: got %0d expected 0", busy_o[0]); end
    total++; if (ovf_o[0] !== 1'b0) begin bad++; $display("FAIL burst_ovf: got %0d expected 0", ovf_o[0]); end
  endtask

  task automatic test_overflow();
    int at [$];
    logic prev;
    do_reset();
    prev = line_o[1];
    for (int i = 0; i < 20; i++) begin
      tick(i < 6, 1'b0);
      if (line_o[1] !== prev) at.push_back(i);
      prev = line_o[1];
      if (i == 3) begin
        total++; if (pend_o[1] !== 8'd3) begin bad++; $display("FAIL ovf_pend_full: got %0d expected 3", pend_o[1]); end
      end
      if (i == 4) begin
        total++; if (ovf_o[1] !== 1'b0) begin bad++; $display("FAIL ovf_early: got %0d expected 0", ovf_o[1]); end
      end
      if (i == 5) begin
        total++; if (ovf_o[1] !== 1'b1) begin bad++; $display("FAIL ovf_set: got %0d expected 1", ovf_o[1]); end
      end
    end
    total++; if (at.size() != 5) begin bad++; $display("FAIL ovf_toggle_count: got %0d expected 5", at.size()); end
    for (int j = 0; j < at.size() && j < 5; j++) begin
      total++; if (at[j] != 4 * j) begin bad++; $display("FAIL ovf_toggle_at[%0d]: got %0d expected %0d", j, at[j], 4 * j); end
    end
    total++; if (line_o[1] !== 1'b1) begin bad++; $display("FAIL ovf_final_line: got %0d expected 1", line_o[1]); end
    total++; if (pend_o[1] !== 8'd0) begin bad++; $display("FAIL ovf_final_pend: got %0d expected 0", pend_o[1]); end
  endtask

  task automatic test_clear_ovf();
    do_reset();
    repeat (5) tick(1'b1, 1'b0);
    total++; if (ovf_o[1] !== 1'b0) begin bad++; $display("FAIL clr_pre: got %0d expected 0", ovf_o[1]); end
    tick(1'b1, 1'b1);
    total++; if (ovf_o[1] !== 1'b1) begin bad++; $display("FAIL clr_set_priority: got %0d expected 1", ovf_o[1]); end
    tick(1'b0, 1'b1);
    total++; if (ovf_o[1] !== 1'b0) begin bad++; $display("FAIL clr_clear: got %0d expected 0", ovf_o[1]); end
  endtask

  task automatic test_async_reset();
    logic prev [N];
    int   changes;
    do_reset();
    repeat (3) tick(1'b1, 1'b0);
    total++; if (pend_o[1] !== 8'd2) begin bad++; $display("FAIL arst_pre_pend: got %0d expected 2", pend_o[1]); end
    total++; if (line_o[1] !== 1'b1) begin bad++; $display("FAIL arst_pre_line: got %0d expected 1", line_o[1]); end
    ev = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < N; d++) begin
      total++;
      if (line_o[d] !== 1'b0 || pend_o[d] !== 8'd0 || ovf_o[d] !== 1'b0 || busy_o[d] !== 1'b0) begin
        bad++;
        $display("FAIL arst_clear[%0d]: got line=%0d pend=%0d ovf=%0d busy=%0d expected all 0", d, line_o[d], pend_o[d], ovf_o[d], busy_o[d]);
      end
    end
    #1;
    reset_n = 1'b1;
    model_init();
    for (int d = 0; d < N; d++) prev[d] = line_o[d];
    changes = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b0);
      for (int d = 0; d < N; d++) begin
        if (line_o[d] !== prev[d]) changes++;
        prev[d] = line_o[d];
      end
    end
    total++; if (changes != 0) begin bad++; $display("FAIL arst_quiet: got %0d toggles expected 0", changes); end
  endtask

  task automatic test_hold1();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 1'b0);
      total++; if (line_o[3] !== 1'((i + 1) % 2)) begin bad++; $display("FAIL hold1_line[%0d]: got %0d expected %0d", i, line_o[3], (i + 1) % 2); end
      total++; if (pend_o[3] !== 8'd0) begin bad++; $display("FAIL hold1_pend[%0d]: got %0d expected 0", i, pend_o[3]); end
    end
    tick(1'b0, 1'b0);
    total++; if (busy_o[3] !== 1'b0) begin bad++; $display("FAIL hold1_idle: got %0d expected 0", busy_o[3]); end
  endtask

  task automatic test_random_loopback();
    int   sent;
    int   gap;
    int   cyc;
    int   pulses;
    int   last_pulse;
    logic prev2;
    bit   e;
    bit   c;
    do_reset();
    sent       = 0;
    cyc        = 0;
    pulses     = 0;
    last_pulse = -100;
    gap        = $urandom_range(0, 3);
    prev2      = line_o[2];
    while ((sent < 200 || busy_m(2)) && cyc < 5000) begin
      e = 1'b0;
      if (sent < 200) begin
        if (gap == 0) begin
          e = 1'b1;
          sent++;
          gap = $urandom_range(0, 3);
        end else begin
          gap--;
        end
      end
      c = ($urandom_range(0, 15) == 0);
      tick(e, c);
      cyc++;
      for (int d = 0; d < N; d++) begin
        total++; if (line_o[d] !== line_m[d]) begin bad++; $display("FAIL rand_line[%0d] cyc %0d: got %0d expected %0d", d, cyc, line_o[d], line_m[d]); end
        total++; if (pend_o[d] !== 8'(pend_m[d])) begin bad++; $display("FAIL rand_pend[%0d] cyc %0d: got %0d expected %0d", d, cyc, pend_o[d], pend_m[d]); end
        total++; if (busy_o[d] !== busy_m(d)) begin bad++; $display("FAIL rand_busy[%0d] cyc %0d: got %0d expected %0d", d, cyc, busy_o[d], busy_m(d)); end
        total++; if (ovf_o[d] !== ovf_m[d]) begin bad++; $display("FAIL rand_ovf[%0d] cyc %0d: got %0d expected %0d", d, cyc, ovf_o[d], ovf_m[d]); end
      end
      // Far-end detector: one pulse per observed level change.
      if (line_o[2] !== prev2) begin
        pulses++;
        total++; if (cyc - last_pulse < 2) begin bad++; $display("FAIL loop_spacing cyc %0d: got %0d expected >=2", cyc, cyc - last_pulse); end
        last_pulse = cyc;
      end
      prev2 = line_o[2];
    end
    total++; if (cyc >= 5000) begin bad++; $display("FAIL loop_timeout: got %0d cycles expected <5000", cyc); end
    total++; if (pulses != 200) begin bad++; $display("FAIL loop_pulses: got %0d expected 200", pulses); end
    total++; if (ovf_o[2] !== 1'b0) begin bad++; $display("FAIL loop_ovf: got %0d expected 0", ovf_o[2]); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_init();
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_clear_ovf();
    test_async_reset();
    test_hold1();
    test_random_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
